// File: rtl/load_store_unit.sv
// Load/store unit: turns one EX/MEM memory request into a held word-addressed
// data-memory access with byte lanes, load extraction, misalign and timeout faults.
module load_store_unit #(
  parameter int unsigned ADDR_W  = 10,
  parameter int unsigned TIMEOUT = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_read,
  input  logic              req_write,
  input  logic [1:0]        req_size,
  input  logic              req_unsigned,
  input  logic [31:0]       alu_res,
  input  logic [31:0]       write_data,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  output logic [3:0]        mem_be,
  output logic              mem_we,
  output logic              mem_re,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ack,
  output logic              stall,
  output logic              resp_valid,
  output logic [31:0]       load_data,
  output logic              misalign,
  output logic              bus_err,
  output logic [31:0]       fault_addr
);

  localparam int unsigned CNT_W = 8;
  localparam int unsigned DATA_W = 32;

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_ACCESS = 2'd1,
    S_RESP   = 2'd2
  } state_e;

  state_e              state_q, state_d;
  logic [CNT_W-1:0]    cnt_q, cnt_d;
  logic [1:0]          off_q, off_d;
  logic [1:0]          size_q, size_d;
  logic                uns_q, uns_d;
  logic                store_q, store_d;
  logic [DATA_W-1:0]   addr_q, addr_d;
  logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
  logic [DATA_W-1:0]   mem_wdata_q, mem_wdata_d;
  logic [3:0]          mem_be_q, mem_be_d;
  logic                mem_we_q, mem_we_d;
  logic                mem_re_q, mem_re_d;
  logic                resp_valid_q, resp_valid_d;
  logic [DATA_W-1:0]   load_data_q, load_data_d;
  logic                misalign_q, misalign_d;
  logic                bus_err_q, bus_err_d;
  logic [DATA_W-1:0]   fault_addr_q, fault_addr_d;

  logic                accept_c;
  logic                misal_c;
  logic                timeout_c;
  logic [3:0]          lane_be_c;
  logic [DATA_W-1:0]   lane_wdata_c;
  logic [7:0]          rd_byte_c;
  logic [15:0]         rd_half_c;
  logic [DATA_W-1:0]   ext_c;

  assign accept_c  = (state_q == S_IDLE) && req_valid && (req_read || req_write);
  assign timeout_c = (cnt_q == CNT_W'(TIMEOUT - 1));

  // Alignment check and lane/data steering for the incoming request
  always_comb begin
    misal_c      = 1'b0;
    lane_be_c    = 4'b1111;
    lane_wdata_c = write_data;
    case (req_size)
      2'b00: begin
        lane_be_c    = 4'b0001 << alu_res[1:0];
        lane_wdata_c = {4{write_data[7:0]}};
      end
      2'b01: begin
        misal_c      = alu_res[0];
        lane_be_c    = 4'b0011 << alu_res[1:0];
        lane_wdata_c = {2{write_data[15:0]}};
      end
      default: begin
        misal_c      = (alu_res[1:0] != 2'b00);
      end
    endcase
  end

  // Load extraction from the returning word using the captured offset/size
  always_comb begin
    rd_byte_c = mem_rdata[7:0];
    case (off_q)
      2'd0:    rd_byte_c = mem_rdata[7:0];
      2'd1:    rd_byte_c = mem_rdata[15:8];
      2'd2:    rd_byte_c = mem_rdata[23:16];
      default: rd_byte_c = mem_rdata[31:24];
    endcase
    rd_half_c = off_q[1] ? mem_rdata[31:16] : mem_rdata[15:0];
    case (size_q)
      2'b00:   ext_c = uns_q ? {24'b0, rd_byte_c} : {{24{rd_byte_c[7]}}, rd_byte_c};
      2'b01:   ext_c = uns_q ? {16'b0, rd_half_c} : {{16{rd_half_c[15]}}, rd_half_c};
      default: ext_c = mem_rdata;
    endcase
    if (store_q) begin
      ext_c = '0;
    end
  end

  // Next-state and registered-output logic
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    off_d        = off_q;
    size_d       = size_q;
    uns_d        = uns_q;
    store_d      = store_q;
    addr_d       = addr_q;
    mem_addr_d   = mem_addr_q;
    mem_wdata_d  = mem_wdata_q;
    mem_be_d     = mem_be_q;
    mem_we_d     = 1'b0;
    mem_re_d     = 1'b0;
    resp_valid_d = 1'b0;
    load_data_d  = '0;
    misalign_d   = 1'b0;
    bus_err_d    = 1'b0;
    fault_addr_d = fault_addr_q;

    case (state_q)
      S_IDLE: begin
        if (accept_c) begin
          off_d   = alu_res[1:0];
          size_d  = req_size;
          uns_d   = req_unsigned;
          store_d = req_write;
          addr_d  = alu_res;
          if (misal_c) begin
            state_d      = S_RESP;
            resp_valid_d = 1'b1;
            misalign_d   = 1'b1;
            fault_addr_d = alu_res;
          end else begin
            state_d     = S_ACCESS;
            cnt_d       = '0;
            mem_addr_d  = alu_res[ADDR_W+1:2];
            mem_be_d    = lane_be_c;
            mem_wdata_d = lane_wdata_c;
            mem_we_d    = req_write;
            mem_re_d    = !req_write;
          end
        end
      end
      S_ACCESS: begin
        if (mem_ack) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          load_data_d  = ext_c;
        end else if (timeout_c) begin
          state_d      = S_RESP;
          resp_valid_d = 1'b1;
          bus_err_d    = 1'b1;
          fault_addr_d = addr_q;
        end else begin
          cnt_d    = cnt_q + CNT_W'(1);
          mem_we_d = mem_we_q;
          mem_re_d = mem_re_q;
        end
      end
      S_RESP: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q      <= S_IDLE;
      cnt_q        <= '0;
      off_q        <= '0;
      size_q       <= '0;
      uns_q        <= 1'b0;
      store_q      <= 1'b0;
      addr_q       <= '0;
      mem_addr_q   <= '0;
      mem_wdata_q  <= '0;
      mem_be_q     <= '0;
      mem_we_q     <= 1'b0;
      mem_re_q     <= 1'b0;
      resp_valid_q <= 1'b0;
      load_data_q  <= '0;
      misalign_q   <= 1'b0;
      bus_err_q    <= 1'b0;
      fault_addr_q <= '0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      off_q        <= off_d;
      size_q       <= size_d;
      uns_q        <= uns_d;
      store_q      <= store_d;
      addr_q       <= addr_d;
      mem_addr_q   <= mem_addr_d;
      mem_wdata_q  <= mem_wdata_d;
      mem_be_q     <= mem_be_d;
      mem_we_q     <= mem_we_d;
      mem_re_q     <= mem_re_d;
      resp_valid_q <= resp_valid_d;
      load_data_q  <= load_data_d;
      misalign_q   <= misalign_d;
      bus_err_q    <= bus_err_d;
      fault_addr_q <= fault_addr_d;
    end
  end

  // Handshake outputs decode the state register (stall also sees same-cycle acceptance)
  assign req_ready  = (state_q == S_IDLE);
  assign stall      = (state_q == S_ACCESS) || accept_c;
  assign mem_addr   = mem_addr_q;
  assign mem_wdata  = mem_wdata_q;
  assign mem_be     = mem_be_q;
  assign mem_we     = mem_we_q;
  assign mem_re     = mem_re_q;
  assign resp_valid = resp_valid_q;
  assign load_data  = load_data_q;
  assign misalign   = misalign_q;
  assign bus_err    = bus_err_q;
  assign fault_addr = fault_addr_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: per-transaction timelines predicted from the access
// rules, compared every cycle, plus directed literal cases and a reset-abort case.
module tb_load_store_unit;

  localparam int unsigned ADDR_W  = 10;
  localparam int unsigned TIMEOUT = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic              req_valid, req_ready, req_read, req_write, req_unsigned;
  logic [1:0]        req_size;
  logic [31:0]       alu_res, write_data;
  logic [ADDR_W-1:0] mem_addr;
  logic [31:0]       mem_wdata, mem_rdata, load_data, fault_addr;
  logic [3:0]        mem_be;
  logic              mem_we, mem_re, mem_ack, stall, resp_valid, misalign, bus_err;

  always #5 clk = ~clk;

  load_store_unit #(.ADDR_W(ADDR_W), .TIMEOUT(TIMEOUT)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_read(req_read), .req_write(req_write), .req_size(req_size),
    .req_unsigned(req_unsigned), .alu_res(alu_res), .write_data(write_data),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_we(mem_we), .mem_re(mem_re), .mem_rdata(mem_rdata), .mem_ack(mem_ack),
    .stall(stall), .resp_valid(resp_valid), .load_data(load_data),
    .misalign(misalign), .bus_err(bus_err), .fault_addr(fault_addr)
  );

  typedef struct packed {
    logic              rdy, stl, we, re, rv, mis, berr;
    logic [ADDR_W-1:0] addr;
    logic [3:0]        be;
    logic [31:0]       wd, ld, fa;
  } exp_t;

  exp_t e;
  logic chk_en = 1'b0;
  int   n_vec  = 0;
  int   n_err  = 0;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s @%0t: got %h expected %h", nm, $time, act, exp);
    end
  endtask

  // Single compare process: DUT outputs vs the predicted cycle
  always @(negedge clk) begin
    if (chk_en) begin
      chk("req_ready", 32'(req_ready), 32'(e.rdy));
      chk("stall", 32'(stall), 32'(e.stl));
      chk("mem_we", 32'(mem_we), 32'(e.we));
      chk("mem_re", 32'(mem_re), 32'(e.re));
      chk("resp_valid", 32'(resp_valid), 32'(e.rv));
      if (e.we || e.re) begin
        chk("mem_addr", 32'(mem_addr), 32'(e.addr));
        chk("mem_be", 32'(mem_be), 32'(e.be));
        chk("mem_wdata", mem_wdata, e.wd);
      end
      if (e.rv) begin
        chk("misalign", 32'(misalign), 32'(e.mis));
        chk("bus_err", 32'(bus_err), 32'(e.berr));
        chk("load_data", load_data, e.ld);
        if (e.mis || e.berr) chk("fault_addr", fault_addr, e.fa);
      end
    end
  end

  function automatic exp_t idle_exp();
    exp_t x = '0;
    x.rdy = 1'b1;
    return x;
  endfunction

  function automatic logic [31:0] model_load(input logic [31:0] rd, input logic [1:0] off,
                                             input logic [1:0] sz, input logic uns);
    int unsigned v;
    v = rd >> (8 * off);
    if (sz == 2'd0) begin
      v = v % 256;
      if (!uns && v >= 128) v = v + 32'hFFFF_FF00;
    end else if (sz == 2'd1) begin
      v = v % 65536;
      if (!uns && v >= 32768) v = v + 32'hFFFF_0000;
    end else begin
      v = rd;
    end
    return v;
  endfunction

  function automatic logic [3:0] model_be(input logic [1:0] sz, input logic [1:0] off);
    int unsigned m;
    m = (sz == 2'd0) ? (1 << off) : (sz == 2'd1) ? (3 << off) : 15;
    return 4'(m);
  endfunction

  function automatic logic [31:0] model_wd(input logic [1:0] sz, input logic [31:0] wd);
    int unsigned w;
    if (sz == 2'd0)      w = (wd % 256) * 32'h0101_0101;
    else if (sz == 2'd1) w = (wd % 65536) * 32'h0001_0001;
    else                 w = wd;
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Idle-cycle inputs: random noise that must never start an access
  task automatic drive_idle_junk();
    req_valid    = 1'($urandom);
    req_read     = 1'b0;
    req_write    = 1'b0;
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    alu_res      = $urandom;
    write_data   = $urandom;
    mem_ack      = 1'($urandom);
    mem_rdata    = $urandom;
  endtask

  // Busy-cycle inputs: a new request attempt that must be refused
  task automatic drive_busy_junk();
    req_valid    = 1'($urandom);
    req_read     = 1'($urandom);
    req_write    = 1'($urandom);
    req_size     = 2'($urandom);
    req_unsigned = 1'($urandom);
    alu_res      = $urandom;
    write_data   = $urandom;
  endtask

  task automatic do_txn(input logic rd, input logic wr, input logic [1:0] sz, input logic uns,
                        input logic [31:0] a, input logic [31:0] wdat, input int dly,
                        input logic [31:0] rdata, input int gap, input logic lit,
                        input logic [3:0] lbe, input logic [31:0] lwd, input logic [31:0] lld);
    logic mis, tmo;
    int   nacc;
    for (int g = 0; g < gap; g++) begin
      step();
      drive_idle_junk();
      e = idle_exp();
    end
    step();
    req_valid    = 1'b1;
    req_read     = rd;
    req_write    = wr;
    req_size     = sz;
    req_unsigned = uns;
    alu_res      = a;
    write_data   = wdat;
    mem_ack      = 1'($urandom);
    mem_rdata    = $urandom;
    e            = idle_exp();
    e.stl        = rd | wr;
    if (!(rd | wr)) return;

    mis = (sz == 2'd1 && (a % 2) != 0) || (sz >= 2'd2 && (a % 4) != 0);
    if (mis) begin
      step();
      drive_busy_junk();
      mem_ack = 1'($urandom);
      e       = '0;
      e.rv    = 1'b1;
      e.mis   = 1'b1;
      e.fa    = a;
      if (lit) begin
        @(negedge clk);
        chk("lit_misalign", 32'(misalign), 32'd1);
        chk("lit_load_data", load_data, lld);
      end
      return;
    end

    tmo  = (dly >= int'(TIMEOUT));
    nacc = tmo ? int'(TIMEOUT) : dly + 1;
    for (int k = 0; k < nacc; k++) begin
      step();
      drive_busy_junk();
      mem_ack   = (k == dly);
      mem_rdata = (k == dly) ? rdata : $urandom;
      e         = '0;
      e.stl     = 1'b1;
      e.we      = wr;
      e.re      = !wr;
      e.addr    = ADDR_W'(a / 4);
      e.be      = model_be(sz, 2'(a % 4));
      e.wd      = model_wd(sz, wdat);
      if (lit && k == 0) begin
        @(negedge clk);
        chk("lit_mem_be", 32'(mem_be), 32'(lbe));
        if (wr) chk("lit_mem_wdata", mem_wdata, lwd);
      end
    end
    step();
    drive_busy_junk();
    mem_ack = 1'($urandom);
    e       = '0;
    e.rv    = 1'b1;
    e.berr  = tmo;
    e.fa    = a;
    e.ld    = (tmo || wr) ? 32'd0 : model_load(rdata, 2'(a % 4), sz, uns);
    if (lit) begin
      @(negedge clk);
      chk("lit_resp_valid", 32'(resp_valid), 32'd1);
      chk("lit_load_data", load_data, lld);
    end
  endtask

  task automatic check_all_zero(input string tag);
    chk({tag, "_req_ready"}, 32'(req_ready), 32'd1);
    chk({tag, "_stall"}, 32'(stall), 32'd0);
    chk({tag, "_resp_valid"}, 32'(resp_valid), 32'd0);
    chk({tag, "_mem_we_re"}, {30'd0, mem_we, mem_re}, 32'd0);
    chk({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    chk({tag, "_mem_be"}, 32'(mem_be), 32'd0);
    chk({tag, "_mem_wdata"}, mem_wdata, 32'd0);
    chk({tag, "_load_data"}, load_data, 32'd0);
    chk({tag, "_flags"}, {30'd0, misalign, bus_err}, 32'd0);
    chk({tag, "_fault_addr"}, fault_addr, 32'd0);
  endtask

  initial begin
    logic [31:0] a, rdv;
    int          r, dly;
    logic        rd, wr;

    reset = 1'b1;
    req_valid = 1'b0; req_read = 1'b0; req_write = 1'b0; req_size = 2'd0;
    req_unsigned = 1'b0; alu_res = '0; write_data = '0; mem_rdata = '0; mem_ack = 1'b0;
    e = idle_exp();
    @(negedge clk);
    check_all_zero("por");
    step();
    reset = 1'b0;
    chk_en = 1'b1;

    // Directed cases with hand-computed literals
    do_txn(1'b0, 1'b1, 2'd2, 1'b0, 32'h10, 32'hDEAD_BEEF, 0, $urandom, 1, 1'b1,
           4'hF, 32'hDEAD_BEEF, 32'h0);
    do_txn(1'b1, 1'b0, 2'd0, 1'b0, 32'h13, 32'h0, 0, 32'h80FF_0000, 0, 1'b1,
           4'h8, 32'h0, 32'hFFFF_FF80);
    do_txn(1'b1, 1'b0, 2'd0, 1'b1, 32'h13, 32'h0, 0, 32'h80FF_0000, 1, 1'b1,
           4'h8, 32'h0, 32'h0000_0080);
    do_txn(1'b0, 1'b1, 2'd1, 1'b0, 32'h22, 32'h1234_ABCD, 2, $urandom, 0, 1'b1,
           4'hC, 32'hABCD_ABCD, 32'h0);
    do_txn(1'b1, 1'b0, 2'd1, 1'b0, 32'h21, 32'h0, 0, $urandom, 1, 1'b1,
           4'h0, 32'h0, 32'h0);
    do_txn(1'b1, 1'b0, 2'd2, 1'b0, 32'h30, 32'h0, 1000, $urandom, 0, 1'b1,
           4'hF, 32'h0, 32'h0);
    do_txn(1'b1, 1'b1, 2'd2, 1'b0, 32'h8, 32'h5555_AAAA, 0, 32'h1234_5678, 1, 1'b1,
           4'hF, 32'h5555_AAAA, 32'h0);
    do_txn(1'b1, 1'b0, 2'd3, 1'b0, 32'h44, 32'h0, int'(TIMEOUT) - 1, 32'hCAFE_F00D, 0, 1'b1,
           4'hF, 32'h0, 32'hCAFE_F00D);
    do_txn(1'b1, 1'b0, 2'd1, 1'b0, 32'h26, 32'h0, 3, 32'h8001_7FFF, 0, 1'b1,
           4'hC, 32'h0, 32'hFFFF_8001);
    do_txn(1'b0, 1'b0, 2'd2, 1'b0, 32'h0, 32'h0, 0, $urandom, 0, 1'b0,
           4'h0, 32'h0, 32'h0);

    // Reset three cycles into an access, then a late ack
    step();
    req_valid = 1'b1; req_read = 1'b1; req_write = 1'b0; req_size = 2'd2;
    alu_res = 32'h40; mem_ack = 1'b0;
    e = idle_exp();
    e.stl = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      req_valid = 1'b0; mem_ack = 1'b0;
      e = '0; e.stl = 1'b1; e.re = 1'b1; e.addr = ADDR_W'(32'h40 / 4); e.be = 4'hF;
      e.wd = model_wd(2'd2, write_data);
    end
    step();
    reset = 1'b1;
    e = idle_exp();
    @(negedge clk);
    check_all_zero("rst_mid");
    step();
    e = idle_exp();
    step();
    reset = 1'b0;
    e = idle_exp();
    step();
    mem_ack = 1'b1;
    e = idle_exp();
    for (int k = 0; k < 3; k++) begin
      step();
      mem_ack = 1'b0;
      e = idle_exp();
    end

    // Randomized traffic
    for (int t = 0; t < 300; t++) begin
      a = $urandom;
      if ($urandom_range(0, 1) == 0) a = a & 32'hFFFF_FFFC;
      r = $urandom_range(0, 9);
      dly = (r < 7) ? (r % 4) : (r == 7) ? int'(TIMEOUT) - 1 :
            (r == 8) ? int'(TIMEOUT) : int'(TIMEOUT) + 5;
      rdv = $urandom;
      rd  = 1'($urandom);
      wr  = 1'($urandom);
      if ($urandom_range(0, 7) != 0 && !(rd | wr)) rd = 1'b1;
      do_txn(rd, wr, 2'($urandom), 1'($urandom), a, $urandom, dly, rdv,
             $urandom_range(0, 2), 1'b0, 4'h0, 32'h0, 32'h0);
    end
    step();
    drive_idle_junk();
    e = idle_exp();
    step();
    chk_en = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
